// File: rtl/tilt_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tilt_emulator
// Purpose  : Synthetic accelerometer source driven by four direction buttons.
//            Produces data_x/data_y samples that ramp toward per-direction
//            target codes at a fixed update rate, with a one-cycle
//            data_update pulse on every update (a periodic refresh, like the
//            real sensor). It stands in for the SPI accelerometer path in
//            front of the spaceship position controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : slowclk            clock, everything on its rising edge
//            reset_n            synchronous, active-low reset
//            en                 update-timer enable; low freezes timer/outputs
//            key_left/right/up/down  raw asynchronous buttons, active-high
//            data_x, data_y     registered 16-bit emulated samples
//            data_update        one-cycle pulse with every sample update
//            x_state, y_state   axis FSM state: 0 IDLE, 1 SLEW, 2 SETTLED
// Options  : TILT_NOISE_EN      when defined, a 16-bit LFSR dithers the low
//                               nibble of each output sample
// ============================================================================
module tilt_emulator #(
  parameter int          UPDATE_DIV = 8,
  parameter int          DEB_CYCLES = 4,
  parameter logic [15:0] REST_VAL   = 16'h3000,
  parameter logic [15:0] HI_VAL     = 16'hF000,
  parameter logic [15:0] LO_VAL     = 16'h0000,
  parameter logic [15:0] STEP       = 16'h0400
) (
  input  logic        slowclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_up,
  input  logic        key_down,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic        data_update,
  output logic [1:0]  x_state,
  output logic [1:0]  y_state
);

  localparam int TW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(UPDATE_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SLEW    = 2'd1,
    ST_SETTLED = 2'd2
  } axis_state_t;

  // Target code from the debounced button pair of one axis.
  function automatic logic [15:0] axis_target(input logic pos, input logic neg);
    logic [15:0] t;
    case ({pos, neg})
      2'b10:   t = HI_VAL;
      2'b01:   t = LO_VAL;
      default: t = REST_VAL;
    endcase
    return t;
  endfunction

  // One slew step; the 17-bit difference keeps the distance test wrap-free.
  function automatic logic [15:0] slew_toward(input logic [15:0] cur, input logic [15:0] tgt);
    logic [16:0] diff;
    logic [15:0] res;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      res  = (diff <= {1'b0, STEP}) ? tgt : cur + STEP;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      res  = (diff <= {1'b0, STEP}) ? tgt : cur - STEP;
    end
    return res;
  endfunction

  // Axis FSM step, evaluated only on a tick. A reversal while slewing keeps
  // SLEW and simply follows the new target on the same tick.
  function automatic axis_state_t axis_next(input axis_state_t st, input logic [15:0] cur,
                                            input logic [15:0] nxt, input logic [15:0] tgt);
    axis_state_t ns;
    ns = st;
    case (st)
      ST_IDLE:    if (tgt != REST_VAL) ns = ST_SLEW;
      ST_SLEW:    if (nxt == tgt) ns = (tgt == REST_VAL) ? ST_IDLE : ST_SETTLED;
      ST_SETTLED: if (tgt != cur) ns = ST_SLEW;
      default:    ns = ST_IDLE;
    endcase
    return ns;
  endfunction

  logic [3:0]          keys_raw;
  logic [3:0]          key_meta_q, key_sync_q;
  logic [3:0]          deb_lvl_q, deb_lvl_d;
  logic [3:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                tick;
  logic [15:0]         target_x, target_y;
  logic [15:0]         cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [15:0]         data_x_q, data_x_d, data_y_q, data_y_d;
  logic                data_update_q, data_update_d;
  axis_state_t         x_state_q, x_state_d, y_state_q, y_state_d;
  logic [15:0]         lfsr_q, lfsr_d;

  assign keys_raw = {key_down, key_up, key_right, key_left};
  assign tick     = en && (timer_q == TMAX);
  assign target_x = axis_target(deb_lvl_q[KEY_RIGHT], deb_lvl_q[KEY_LEFT]);
  assign target_y = axis_target(deb_lvl_q[KEY_UP], deb_lvl_q[KEY_DOWN]);

  always_comb begin
    // Debounce: the level flips once DEB_CYCLES consecutive synced samples
    // disagree with it; any agreeing sample restarts the run.
    deb_lvl_d = deb_lvl_q;
    deb_cnt_d = deb_cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (key_sync_q[k] != deb_lvl_q[k]) begin
        if (deb_cnt_q[k] == DEB_MAX) begin
          deb_lvl_d[k] = key_sync_q[k];
          deb_cnt_d[k] = '0;
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
        end
      end else begin
        deb_cnt_d[k] = '0;
      end
    end

    timer_d = timer_q;
    if (en) timer_d = (timer_q == TMAX) ? '0 : timer_q + TW'(1);

    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    x_state_d     = x_state_q;
    y_state_d     = y_state_q;
    data_x_d      = data_x_q;
    data_y_d      = data_y_q;
    lfsr_d        = lfsr_q;
    data_update_d = tick;

    if (tick) begin
      cur_x_d   = slew_toward(cur_x_q, target_x);
      cur_y_d   = slew_toward(cur_y_q, target_y);
      x_state_d = axis_next(x_state_q, cur_x_q, cur_x_d, target_x);
      y_state_d = axis_next(y_state_q, cur_y_q, cur_y_d, target_y);
`ifdef TILT_NOISE_EN
      // Fibonacci LFSR, taps 16,14,13,11; dither touches the outputs only.
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      data_x_d = {cur_x_d[15:8], 4'h0, lfsr_d[3:0]};
      data_y_d = {cur_y_d[15:8], 4'h0, lfsr_d[7:4]};
`else
      data_x_d = {cur_x_d[15:8], 8'h00};
      data_y_d = {cur_y_d[15:8], 8'h00};
`endif
    end
  end

  always_ff @(posedge slowclk) begin
    if (!reset_n) begin
      key_meta_q    <= '0;
      key_sync_q    <= '0;
      deb_lvl_q     <= '0;
      deb_cnt_q     <= '0;
      timer_q       <= '0;
      cur_x_q       <= REST_VAL;
      cur_y_q       <= REST_VAL;
      data_x_q      <= REST_VAL;
      data_y_q      <= REST_VAL;
      data_update_q <= 1'b0;
      x_state_q     <= ST_IDLE;
      y_state_q     <= ST_IDLE;
      lfsr_q        <= 16'hACE1;
    end else begin
      key_meta_q    <= keys_raw;
      key_sync_q    <= key_meta_q;
      deb_lvl_q     <= deb_lvl_d;
      deb_cnt_q     <= deb_cnt_d;
      timer_q       <= timer_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      data_x_q      <= data_x_d;
      data_y_q      <= data_y_d;
      data_update_q <= data_update_d;
      x_state_q     <= x_state_d;
      y_state_q     <= y_state_d;
      lfsr_q        <= lfsr_d;
    end
  end

  assign data_x      = data_x_q;
  assign data_y      = data_y_q;
  assign data_update = data_update_q;
  assign x_state     = x_state_q;
  assign y_state     = y_state_q;

endmodule
`default_nettype wire

// File: tb/tb_tilt_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tilt_emulator
// Purpose  : Self-checking bench for tilt_emulator. A behavioural reference
//            model pushes the expected sample into a scoreboard queue on every
//            modelled update tick; the monitor pops and compares it when the
//            design pulses data_update. Directed phases cover the idle
//            refresh, ramps, reversal, debounce glitch, enable freeze and a
//            mid-slew reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tilt_emulator;

  localparam int          UPDATE_DIV = 8;
  localparam int          DEB        = 4;
  localparam logic [15:0] REST       = 16'h3000;
  localparam logic [15:0] HI         = 16'hF000;
  localparam logic [15:0] LO         = 16'h0000;
  localparam int          STEP_I     = 1024;

  logic        slowclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b1;
  logic        key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic [15:0] data_x, data_y;
  logic        data_update;
  logic [1:0]  x_state, y_state;

  tilt_emulator dut (
    .slowclk     (slowclk),
    .reset_n     (reset_n),
    .en          (en),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_up      (key_up),
    .key_down    (key_down),
    .data_x      (data_x),
    .data_y      (data_y),
    .data_update (data_update),
    .x_state     (x_state),
    .y_state     (y_state)
  );

  always #5 slowclk = ~slowclk;

  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_on = 1'b0;
  logic [35:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  m_s1, m_s2, m_lvl, m_keys;
  int          m_run [4];
  int          m_cnt;
  logic [15:0] m_x, m_y, m_lfsr;
  int          m_xs, m_ys;
  logic        m_upd;

  task automatic step_axis(inout logic [15:0] cur, inout int st, input logic [15:0] tgt);
    int c, t;
    logic [15:0] old;
    old = cur;
    c = int'(cur);
    t = int'(tgt);
    if (t > c)      c = (t - c <= STEP_I) ? t : c + STEP_I;
    else if (c > t) c = (c - t <= STEP_I) ? t : c - STEP_I;
    cur = 16'(c);
    if (st == 0) begin
      if (tgt != REST) st = 1;
    end else if (st == 1) begin
      if (cur == tgt) st = (tgt == REST) ? 0 : 2;
    end else begin
      if (tgt != old) st = 1;
    end
  endtask

  function automatic logic [15:0] tgt_of(input logic pos, input logic neg);
    if (pos && !neg) return HI;
    if (neg && !pos) return LO;
    return REST;
  endfunction

  always @(posedge slowclk) begin
    logic [15:0] tx, ty, ex, ey;
    m_keys = {key_down, key_up, key_right, key_left};
    if (!reset_n) begin
      m_cnt = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int k = 0; k < 4; k++) m_run[k] = 0;
      m_x = REST; m_y = REST; m_xs = 0; m_ys = 0; m_upd = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      m_upd = en && (m_cnt == UPDATE_DIV - 1);
      if (en) m_cnt = (m_cnt == UPDATE_DIV - 1) ? 0 : m_cnt + 1;
      if (m_upd) begin
        tx = tgt_of(m_lvl[1], m_lvl[0]);
        ty = tgt_of(m_lvl[2], m_lvl[3]);
        step_axis(m_x, m_xs, tx);
        step_axis(m_y, m_ys, ty);
        ex = {m_x[15:8], 8'h00};
        ey = {m_y[15:8], 8'h00};
`ifdef TILT_NOISE_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        ex[3:0] = m_lfsr[3:0];
        ey[3:0] = m_lfsr[7:4];
`endif
        sb.push_back({ex, ey, 2'(m_xs), 2'(m_ys)});
      end
      for (int k = 0; k < 4; k++) begin
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] >= DEB) begin
            m_lvl[k] = m_s2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = m_keys;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge slowclk) begin
    logic [35:0] e;
    if (mon_on) begin
      chk("upd", {31'd0, data_update}, {31'd0, m_upd});
      if (data_update) begin
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_x", {16'd0, data_x}, {16'd0, e[35:20]});
          chk("sb_y", {16'd0, data_y}, {16'd0, e[19:4]});
          chk("sb_xs", {30'd0, x_state}, {30'd0, e[3:2]});
          chk("sb_ys", {30'd0, y_state}, {30'd0, e[1:0]});
        end
      end
    end
  end

  task automatic wait_axis(input bit is_y, input logic [15:0] v, input int bound, input string tag);
    for (int i = 0; i < bound && (is_y ? data_y : data_x) !== v; i++) @(negedge slowclk);
    chk(tag, {16'd0, is_y ? data_y : data_x}, {16'd0, v});
  endtask

  // ---------------- directed phases ----------------
  initial begin
    int pulses, n3000, nupd;
    logic [15:0] held;

    repeat (3) @(negedge slowclk);
    chk("rst_x", {16'd0, data_x}, {16'd0, REST});
    chk("rst_y", {16'd0, data_y}, {16'd0, REST});
    chk("rst_upd", {31'd0, data_update}, 32'd0);
    chk("rst_xs", {30'd0, x_state}, 32'd0);
    chk("rst_ys", {30'd0, y_state}, 32'd0);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // Idle refresh: a pulse every UPDATE_DIV cycles, values at rest.
    pulses = 0;
    repeat (40) begin
      @(negedge slowclk);
      if (data_update) pulses++;
    end
    chk("idle_pulses", pulses, 5);
    chk("idle_x", {16'd0, data_x}, {16'd0, REST});
    chk("idle_xs", {30'd0, x_state}, 32'd0);
    chk("idle_ys", {30'd0, y_state}, 32'd0);

    // Ramp right up to HI.
    key_right = 1'b1;
    wait_axis(1'b0, HI, 700, "ramp_hi");
    chk("hi_xs", {30'd0, x_state}, 32'd2);

    // Reversal: ramp straight through REST down to LO.
    key_right = 1'b0;
    key_left  = 1'b1;
    n3000 = 0;
    for (int i = 0; i < 800 && data_x !== LO; i++) begin
      @(negedge slowclk);
      if (data_update && data_x == REST) begin
        n3000++;
        chk("rev_slew", {30'd0, x_state}, 32'd1);
      end
    end
    chk("ramp_lo", {16'd0, data_x}, {16'd0, LO});
    chk("no_stall", n3000, 1);
    chk("lo_xs", {30'd0, x_state}, 32'd2);

    // Release: back to REST and IDLE.
    key_left = 1'b0;
    wait_axis(1'b0, REST, 300, "back_rest");
    chk("rest_xs", {30'd0, x_state}, 32'd0);

    // Opposite keys together and a short glitch leave y at rest.
    key_up = 1'b1;
    key_down = 1'b1;
    repeat (40) @(negedge slowclk);
    chk("both_y", {16'd0, data_y}, {16'd0, REST});
    chk("both_ys", {30'd0, y_state}, 32'd0);
    key_up = 1'b0;
    key_down = 1'b0;
    repeat (20) @(negedge slowclk);
    key_up = 1'b1;
    repeat (3) @(negedge slowclk);
    key_up = 1'b0;
    repeat (40) @(negedge slowclk);
    chk("glitch_y", {16'd0, data_y}, {16'd0, REST});
    chk("glitch_ys", {30'd0, y_state}, 32'd0);

    // Enable freeze during a slew.
    key_up = 1'b1;
    wait_axis(1'b1, 16'h4000, 200, "y_4000");
    en = 1'b0;
    held = data_y;
    nupd = 0;
    repeat (20) begin
      @(negedge slowclk);
      if (data_update) nupd++;
    end
    chk("frz_upd", nupd, 0);
    chk("frz_y", {16'd0, data_y}, {16'd0, held});
    chk("frz_ys", {30'd0, y_state}, 32'd1);
    en = 1'b1;
    wait_axis(1'b1, HI, 800, "y_hi");
    chk("y_hi_ys", {30'd0, y_state}, 32'd2);

    // Reset in the middle of an x slew.
    key_up = 1'b0;
    key_right = 1'b1;
    wait_axis(1'b0, 16'h8000, 400, "x_8000");
    reset_n = 1'b0;
    @(negedge slowclk);
    chk("mid_rst_x", {16'd0, data_x}, {16'd0, REST});
    chk("mid_rst_y", {16'd0, data_y}, {16'd0, REST});
    chk("mid_rst_xs", {30'd0, x_state}, 32'd0);
    chk("mid_rst_upd", {31'd0, data_update}, 32'd0);
    reset_n = 1'b1;
    key_right = 1'b0;
    repeat (100) @(negedge slowclk);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
